assoc_cache: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache with one word per line.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/assoc_cache_if.sv | 39 +++
 rtl/cache_way.sv | 58 +++++
 rtl/assoc_cache.sv | 266 ++++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and helpers for the set-associative data cache.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITEBACK = 3'd1,
        REFILL    = 3'd2,
        RESPOND   = 3'd3,
        FLUSH     = 3'd4
    } cache_state_e;

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int sets);
        return addr_w - 2 - $clog2(sets);
    endfunction

    // Replace only the byte lanes selected by be; be[0] covers bits 7:0.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_cache_if.sv
// ============================================================================
//  Module      : assoc_cache_if
//  Description : CPU-side and memory-side buses of the data cache.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface assoc_cache_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [3:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // The cache itself: serves the CPU, masters memory.
    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    // The surrounding environment: CPU core plus data memory.
    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cache_way.sv
// ============================================================================
//  Module      : cache_way
//  Description : One way of the cache: data/tag/valid/dirty per set, async read.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_way #(
    parameter int SETS  = 2048,
    parameter int IDX_W = 11,
    parameter int TAG_W = 19
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [IDX_W-1:0] i_ridx,
    output logic      [31:0]      o_rdata,
    output logic      [TAG_W-1:0] o_rtag,
    output logic                  o_rvalid,
    output logic                  o_rdirty,
    input  wire logic             i_we,
    input  wire logic [IDX_W-1:0] i_widx,
    input  wire logic [31:0]      i_wdata,
    input  wire logic [TAG_W-1:0] i_wtag,
    input  wire logic             i_wvalid,
    input  wire logic             i_wdirty
);

    logic [31:0]      r_data [SETS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;
    logic [SETS-1:0]  r_dirty;

    // Payload needs no reset: a line is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_data[i_widx] <= i_wdata;
            r_tag[i_widx]  <= i_wtag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= i_wvalid;
            r_dirty[i_widx] <= i_wdirty;
        end
    end

    assign o_rdata  = r_data[i_ridx];
    assign o_rtag   = r_tag[i_ridx];
    assign o_rvalid = r_valid[i_ridx];
    assign o_rdirty = r_dirty[i_ridx];

endmodule

`default_nettype wire

// File: rtl/assoc_cache.sv
// ============================================================================
//  Module      : assoc_cache
//  Description : N-way set-associative write-back/write-allocate data cache.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SETS   = 2048,
    parameter int WAYS   = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    assoc_cache_if.slave      bus,
    input  wire logic         flush_req,
    output logic              flush_done,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int c_idx_w = calc_idx_w(SETS);
    localparam int c_tag_w = calc_tag_w(ADDR_W, SETS);
    localparam int c_way_w = (WAYS > 1) ? $clog2(WAYS) : 1;

    cache_state_e        r_state;
    logic                r_cpu_ready;
    logic [31:0]         r_cpu_rdata;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_flush_done;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;
    logic [c_way_w-1:0]  r_vway;
    logic [c_idx_w-1:0]  r_flush_set;
    logic [c_way_w-1:0]  r_flush_way;
    logic [c_way_w-1:0]  r_ptr [SETS];

    logic [c_idx_w-1:0]  w_req_idx;
    logic [c_tag_w-1:0]  w_req_tag;
    logic [c_idx_w-1:0]  w_ridx;
    logic [31:0]         w_rd_data [WAYS];
    logic [c_tag_w-1:0]  w_rd_tag  [WAYS];
    logic [WAYS-1:0]     w_rd_valid;
    logic [WAYS-1:0]     w_rd_dirty;
    logic [WAYS-1:0]     w_we;
    logic [c_idx_w-1:0]  w_widx;
    logic [31:0]         w_wdata;
    logic [c_tag_w-1:0]  w_wtag;
    logic                w_wvalid;
    logic                w_wdirty;
    logic                w_hit;
    logic [c_way_w-1:0]  w_hit_way;
    logic                w_inv_found;
    logic [c_way_w-1:0]  w_inv_way;
    logic [c_way_w-1:0]  w_victim;
    logic [c_way_w-1:0]  w_ptr_next;
    logic [c_way_w-1:0]  w_merge_way;
    logic [31:0]         w_merged;
    logic                w_accept;
    logic                w_ack;
    logic                w_fl_dirty;
    logic                w_fl_last;
    logic                w_fl_step;
    logic                w_unused;

    assign w_req_idx = bus.cpu_addr[c_idx_w+1:2];
    assign w_req_tag = bus.cpu_addr[ADDR_W-1:c_idx_w+2];
    assign w_unused  = ^bus.cpu_addr[1:0];
    assign w_ridx    = (r_state == FLUSH) ? r_flush_set : w_req_idx;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            cache_way #(
                .SETS  (SETS),
                .IDX_W (c_idx_w),
                .TAG_W (c_tag_w)
            ) u_way (
                .clk      (clk),
                .rst      (rst),
                .i_ridx   (w_ridx),
                .o_rdata  (w_rd_data[g]),
                .o_rtag   (w_rd_tag[g]),
                .o_rvalid (w_rd_valid[g]),
                .o_rdirty (w_rd_dirty[g]),
                .i_we     (w_we[g]),
                .i_widx   (w_widx),
                .i_wdata  (w_wdata),
                .i_wtag   (w_wtag),
                .i_wvalid (w_wvalid),
                .i_wdirty (w_wdirty)
            );
        end
    endgenerate

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rd_valid[w] && (w_rd_tag[w] == w_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(w);
            end
            if (!w_rd_valid[w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_way_w'(w);
            end
        end
    end

    assign w_victim    = w_inv_found ? w_inv_way : r_ptr[w_req_idx];
    assign w_ptr_next  = (r_ptr[w_req_idx] == c_way_w'(WAYS - 1)) ? '0 : r_ptr[w_req_idx] + 1'b1;
    assign w_merge_way = (r_state == RESPOND) ? r_vway : w_hit_way;
    assign w_merged    = byte_merge(w_rd_data[w_merge_way], bus.cpu_wdata, bus.cpu_be);
    assign w_accept    = (r_state == IDLE) && !flush_req && bus.cpu_req && !r_cpu_ready;
    assign w_ack       = r_mem_req && bus.mem_ack;
    assign w_fl_dirty  = w_rd_valid[r_flush_way] && w_rd_dirty[r_flush_way];
    assign w_fl_last   = (r_flush_set == {c_idx_w{1'b1}}) && (r_flush_way == c_way_w'(WAYS - 1));
    assign w_fl_step   = (r_state == FLUSH) && (r_mem_req ? bus.mem_ack : !w_fl_dirty);

    always_comb begin
        w_we     = '0;
        w_widx   = w_req_idx;
        w_wdata  = w_merged;
        w_wtag   = w_req_tag;
        w_wvalid = 1'b1;
        w_wdirty = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_accept && w_hit && bus.cpu_we) w_we[w_hit_way] = 1'b1;
            end
            REFILL: begin
                if (w_ack) begin
                    w_we[r_vway] = 1'b1;
                    w_wdata      = bus.mem_rdata;
                    w_wdirty     = 1'b0;
                end
            end
            RESPOND: begin
                if (bus.cpu_we) w_we[r_vway] = 1'b1;
            end
            FLUSH: begin
                if (w_ack) begin
                    w_we[r_flush_way] = 1'b1;
                    w_widx            = r_flush_set;
                    w_wdata           = w_rd_data[r_flush_way];
                    w_wtag            = w_rd_tag[r_flush_way];
                    w_wdirty          = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // r_cpu_ready blocks re-acceptance of the request the CPU is still holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cpu_ready  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_flush_done <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_vway       <= '0;
            r_flush_set  <= '0;
            r_flush_way  <= '0;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else begin
            r_cpu_ready  <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_req) begin
                        r_state     <= FLUSH;
                        r_flush_set <= '0;
                        r_flush_way <= '0;
                    end else if (w_accept) begin
                        if (w_hit) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_rdata <= w_rd_data[w_hit_way];
                            r_hit_cnt   <= r_hit_cnt + 32'd1;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 32'd1;
                            r_vway     <= w_victim;
                            r_mem_req  <= 1'b1;
                            if (w_rd_valid[w_victim] && w_rd_dirty[w_victim]) begin
                                r_state     <= WRITEBACK;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= {w_rd_tag[w_victim], w_req_idx, 2'b00};
                                r_mem_wdata <= w_rd_data[w_victim];
                            end else begin
                                r_state    <= REFILL;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= {w_req_tag, w_req_idx, 2'b00};
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (w_ack) begin
                        r_state    <= REFILL;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_req_tag, w_req_idx, 2'b00};
                    end
                end
                REFILL: begin
                    if (w_ack) begin
                        r_state           <= RESPOND;
                        r_mem_req         <= 1'b0;
                        r_ptr[w_req_idx]  <= w_ptr_next;
                    end
                end
                RESPOND: begin
                    r_state     <= IDLE;
                    r_cpu_ready <= 1'b1;
                    r_cpu_rdata <= w_rd_data[r_vway];
                end
                FLUSH: begin
                    if (w_ack) r_mem_req <= 1'b0;
                    if (!r_mem_req && w_fl_dirty) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {w_rd_tag[r_flush_way], r_flush_set, 2'b00};
                        r_mem_wdata <= w_rd_data[r_flush_way];
                    end
                    if (w_fl_step) begin
                        if (w_fl_last) begin
                            r_state      <= IDLE;
                            r_flush_done <= 1'b1;
                        end else if (r_flush_way == c_way_w'(WAYS - 1)) begin
                            r_flush_way <= '0;
                            r_flush_set <= r_flush_set + 1'b1;
                        end else begin
                            r_flush_way <= r_flush_way + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign flush_done    = r_flush_done;
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_assoc_cache.sv
// ============================================================================
//  Module      : tb_assoc_cache
//  Description : Self-checking bench for assoc_cache (SETS=2048, WAYS=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_assoc_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    assoc_cache_if #(.ADDR_W(32)) bus ();

    assoc_cache #(
        .ADDR_W (32),
        .SETS   (2048),
        .WAYS   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_op_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic        wb;
        logic [31:0] wb_addr;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_hi = 0;
    int          rdy_in_req = 0;
    int          wb_seen = 0;
    mem_op_t     exp_mem_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    vec_t        vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1122_3344;
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Memory responder: acks after ack_delay idle cycles, logs and checks each op.
    task automatic serve();
        mem_op_t e;
        if (exp_mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_op unexpected: got we=%0d addr=0x%08h expected none", bus.mem_we, bus.mem_addr);
        end else begin
            e = exp_mem_q.pop_front();
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
            check("mem_addr", bus.mem_addr, e.addr);
            if (e.we) check("mem_wdata", bus.mem_wdata, e.data);
        end
        if (bus.mem_we) begin
            mem_arr[bus.mem_addr] = bus.mem_wdata;
            wb_seen++;
        end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) req_hi++;
            if (bus.cpu_ready && bus.mem_req) rdy_in_req++;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
            end else if (!bus.mem_req || rst) begin
                wait_cnt = 0;
            end else if (wait_cnt < ack_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                serve();
                bus.mem_ack = 1'b1;
            end
        end
    end

    task automatic cpu_access(input string name, input vec_t v);
        logic [31:0] a;
        logic [31:0] exp_rd;
        int          cyc;
        a = {v.addr[31:2], 2'b00};
        @(posedge clk);
        #1;
        if (v.hit) begin
            exp_hits++;
        end else begin
            exp_misses++;
            if (v.wb) exp_mem_q.push_back(mem_op_t'{1'b1, v.wb_addr, ref_rd(v.wb_addr)});
            exp_mem_q.push_back(mem_op_t'{1'b0, a, 32'h0});
        end
        rd_q.push_back(ref_rd(a));
        if (v.we) ref_mem[a] = (ref_rd(a) & ~lane_mask(v.be)) | (v.wdata & lane_mask(v.be));
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = v.we;
        bus.cpu_be    = v.be;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.cpu_ready && cyc < 100);
        bus.cpu_req = 1'b0;
        exp_rd = rd_q.pop_front();
        if (!bus.cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no cpu_ready expected within 100 cycles", name);
        end else begin
            if (!v.we) check({name, " rdata"}, bus.cpu_rdata, exp_rd);
            if (v.hit) check({name, " hit latency"}, cyc, 1);
            check({name, " hit_cnt"}, hit_cnt, exp_hits);
            check({name, " miss_cnt"}, miss_cnt, exp_misses);
        end
    endtask

    task automatic do_flush(input string name, input int exp_wb);
        int cyc;
        wb_seen = 0;
        @(posedge clk);
        #1;
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        cyc = 0;
        while (!flush_done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, " flush_done"}, {31'd0, flush_done}, 32'd1);
        check({name, " writebacks"}, wb_seen, exp_wb);
        @(posedge clk);
        #1;
        check({name, " flush_done pulse"}, {31'd0, flush_done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected before 2ms");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000_0100, 32'h0000_AB00, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'hC, 32'h0000_2000, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_4000, 32'h0,         1'b0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0000_2000};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0000_4000, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h0};

        rst           = 1'b1;
        flush_req     = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = 4'h0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rst flush_done", {31'd0, flush_done}, 32'd0);
        check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst mem_addr", bus.mem_addr, 32'd0);
        check("rst mem_wdata", bus.mem_wdata, 32'd0);
        check("rst hit_cnt", hit_cnt, 32'd0);
        check("rst miss_cnt", miss_cnt, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            cpu_access($sformatf("vec%0d", i), vecs[i]);
        end

        // Slow memory: mem_req must stay up for the full wait, no early ready.
        ack_delay  = 6;
        req_hi     = 0;
        rdy_in_req = 0;
        cpu_access("slow refill", '{1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b0, 1'b0, 32'h0});
        check("slow mem_req cycles", req_hi, 7);
        check("slow ready during req", rdy_in_req, 0);
        ack_delay = 0;

        cpu_access("pre-flush store", '{1'b1, 4'hF, 32'h0000_0108, 32'h1234_5678, 1'b0, 1'b0, 32'h0});
        exp_mem_q.push_back(mem_op_t'{1'b1, 32'h0000_0000, ref_rd(32'h0000_0000)});
        exp_mem_q.push_back(mem_op_t'{1'b1, 32'h0000_0100, ref_rd(32'h0000_0100)});
        exp_mem_q.push_back(mem_op_t'{1'b1, 32'h0000_0108, ref_rd(32'h0000_0108)});
        do_flush("flush1", 3);
        do_flush("flush2", 0);
        cpu_access("post-flush hit", '{1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h0});

        // Reset during the second REFILL cycle must abort the memory request.
        ack_delay = 20;
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 4'h0;
        bus.cpu_addr = 32'h0000_0200;
        for (int c = 0; c < 10 && !bus.mem_req; c++) begin
            @(posedge clk);
            #1;
        end
        check("abort mem_req raised", {31'd0, bus.mem_req}, 32'd1);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort mem_req dropped", {31'd0, bus.mem_req}, 32'd0);
        rst        = 1'b0;
        ack_delay  = 0;
        exp_hits   = 0;
        exp_misses = 0;
        check("abort hit_cnt", hit_cnt, 32'd0);
        check("abort miss_cnt", miss_cnt, 32'd0);
        cpu_access("reload after abort", '{1'b0, 4'h0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'h0});

        repeat (3) @(posedge clk);
        check("mem ops outstanding", exp_mem_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
